// File: rtl/spy_pkg.sv
// Shared definitions for the spy buffer: playback mode codes, write-side state
// encoding and the initial (all ones) write address.
package spy_pkg;

  localparam logic [1:0] NO_PLAYBACK    = 2'b00;
  localparam logic [1:0] PLAYBACK_ONCE  = 2'b01;
  localparam logic [1:0] PLAYBACK_LOOP  = 2'b10;
  localparam logic [1:0] PLAYBACK_WRITE = 2'b11;

  typedef enum logic [1:0] {
    ST_RECORD   = 2'b00,
    ST_FREEZING = 2'b01,
    ST_FROZEN   = 2'b10,
    ST_PLAYBACK = 2'b11
  } spy_state_t;

  // The address register starts at all ones so the first write lands on 0.
  function automatic logic [31:0] spy_init_addr(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/spy_sat_counter.sv
// Saturating up-counter with a synchronous clear; a clear together with an
// increment restarts the count at one.
module spy_sat_counter #(
  parameter int unsigned WIDTH = 16,
  parameter logic [WIDTH-1:0] MAX_VALUE = {WIDTH{1'b1}}
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             increment,
  output logic [WIDTH-1:0] count
);

  // Count register: clear has priority, then saturating increment.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= {WIDTH{1'b0}};
    end else if (clear) begin
      count <= increment ? WIDTH'(1) : {WIDTH{1'b0}};
    end else if (increment && (count != MAX_VALUE)) begin
      count <= count + WIDTH'(1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/spy_write_controller.sv
// Write stage of the spy buffer: records the upstream stream, freezes after a
// trigger and forwards playback block writes. Option: SPY_META_FREEZE_EN.
module spy_write_controller
  import spy_pkg::*;
#(
  parameter int unsigned DATAWIDTH = 64,
  parameter int unsigned MEMWIDTH  = 6,
  parameter int unsigned DROPWIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 write_enable,
  input  logic [DATAWIDTH:0]   write_data,
  input  logic [1:0]           playback,
  input  logic                 ram_write_enable,
  input  logic [DATAWIDTH:0]   ram_write_data,
  input  logic                 freeze_request,
  input  logic [MEMWIDTH-1:0]  freeze_delay,
  input  logic                 freeze_clear,
  output logic                 spy_write_enable,
  output logic [MEMWIDTH-1:0]  spy_write_addr,
  output logic [DATAWIDTH:0]   spy_write_data,
  output logic                 frozen,
  output logic [MEMWIDTH:0]    word_count,
  output logic [DROPWIDTH-1:0] dropped_count
);

  localparam logic [MEMWIDTH-1:0] INIT_ADDR = MEMWIDTH'(spy_init_addr(MEMWIDTH));
  localparam logic [MEMWIDTH:0]   FULL_COUNT = {1'b1, {MEMWIDTH{1'b0}}};

  spy_state_t          state_r;
  spy_state_t          state_next_s;
  logic [1:0]          playback_prev_r;
  logic [MEMWIDTH-1:0] remaining_r;
  logic [MEMWIDTH-1:0] remaining_next_s;
  logic [MEMWIDTH-1:0] addr_base_s;
  logic [DATAWIDTH:0]  src_data_s;
  logic                accept_s;
  logic                drop_s;
  logic                restart_s;
  logic                dec_s;
  logic                count_word_s;

`ifdef SPY_META_FREEZE_EN
  assign count_word_s = write_data[DATAWIDTH];
`else
  assign count_word_s = 1'b1;
`endif

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_RECORD;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; any active playback code overrides everything else.
  always_comb begin
    state_next_s = state_r;
    if (playback != NO_PLAYBACK) begin
      state_next_s = ST_PLAYBACK;
    end else begin
      case (state_r)
        ST_RECORD: begin
          if (freeze_clear) begin
            state_next_s = ST_RECORD;
          end else if (freeze_request) begin
            state_next_s = (freeze_delay == {MEMWIDTH{1'b0}}) ? ST_FROZEN : ST_FREEZING;
          end else begin
            state_next_s = ST_RECORD;
          end
        end
        ST_FREEZING: begin
          if (freeze_clear) begin
            state_next_s = ST_RECORD;
          end else if (dec_s && (remaining_r == MEMWIDTH'(1))) begin
            state_next_s = ST_FROZEN;
          end else begin
            state_next_s = ST_FREEZING;
          end
        end
        ST_FROZEN:   state_next_s = freeze_clear ? ST_RECORD : ST_FROZEN;
        ST_PLAYBACK: state_next_s = ST_FROZEN;
        default:     state_next_s = ST_RECORD;
      endcase
    end
  end

  // Per-cycle write/drop decisions and the freeze countdown.
  always_comb begin
    accept_s         = 1'b0;
    drop_s           = 1'b0;
    restart_s        = 1'b0;
    src_data_s       = write_data;
    remaining_next_s = remaining_r;
    if (playback != NO_PLAYBACK) begin
      drop_s    = write_enable;
      restart_s = (playback == PLAYBACK_WRITE) && (playback_prev_r != PLAYBACK_WRITE);
      if (playback == PLAYBACK_WRITE) begin
        accept_s   = ram_write_enable;
        src_data_s = ram_write_data;
      end else begin
        accept_s   = 1'b0;
      end
    end else begin
      case (state_r)
        ST_RECORD, ST_FREEZING: accept_s = write_enable;
        ST_FROZEN, ST_PLAYBACK: drop_s   = write_enable;
        default:                drop_s   = write_enable;
      endcase
    end
    dec_s = accept_s && (state_r == ST_FREEZING) && (playback == NO_PLAYBACK) && count_word_s;
    if ((state_r == ST_RECORD) && (playback == NO_PLAYBACK) && freeze_request && !freeze_clear) begin
      remaining_next_s = freeze_delay;
    end else if (dec_s && (remaining_r != {MEMWIDTH{1'b0}})) begin
      remaining_next_s = remaining_r - MEMWIDTH'(1);
    end else begin
      remaining_next_s = remaining_r;
    end
    addr_base_s = restart_s ? INIT_ADDR : spy_write_addr;
  end

  // Registered write port, frozen flag and countdown.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      spy_write_enable <= 1'b0;
      spy_write_addr   <= INIT_ADDR;
      spy_write_data   <= {(DATAWIDTH+1){1'b0}};
      frozen           <= 1'b0;
      remaining_r      <= {MEMWIDTH{1'b0}};
      playback_prev_r  <= NO_PLAYBACK;
    end else begin
      spy_write_enable <= accept_s;
      frozen           <= (state_next_s == ST_FROZEN);
      remaining_r      <= remaining_next_s;
      playback_prev_r  <= playback;
      if (accept_s) begin
        spy_write_addr <= addr_base_s + MEMWIDTH'(1);
        spy_write_data <= src_data_s;
      end else begin
        spy_write_addr <= addr_base_s;
        spy_write_data <= spy_write_data;
      end
    end
  end

  spy_sat_counter #(
    .WIDTH     (MEMWIDTH + 1),
    .MAX_VALUE (FULL_COUNT)
  ) u_word_count (
    .clock     (clock),
    .reset     (reset),
    .clear     (restart_s),
    .increment (accept_s),
    .count     (word_count)
  );

  spy_sat_counter #(
    .WIDTH     (DROPWIDTH),
    .MAX_VALUE ({DROPWIDTH{1'b1}})
  ) u_dropped_count (
    .clock     (clock),
    .reset     (reset),
    .clear     (1'b0),
    .increment (drop_s),
    .count     (dropped_count)
  );

endmodule

// File: tb/tb_spy_write_controller.sv
// Self-checking bench for spy_write_controller: hand-derived vector table,
// directed corner sequences and randomized traffic against a behavioural model.
module tb_spy_write_controller;
  import spy_pkg::*;

  localparam int DW = 64;
  localparam int MW = 6;
  localparam int DEPTH = 1 << MW;

  logic          clock;
  logic          reset;
  logic          write_enable;
  logic [DW:0]   write_data;
  logic [1:0]    playback;
  logic          ram_write_enable;
  logic [DW:0]   ram_write_data;
  logic          freeze_request;
  logic [MW-1:0] freeze_delay;
  logic          freeze_clear;
  logic          spy_write_enable;
  logic [MW-1:0] spy_write_addr;
  logic [DW:0]   spy_write_data;
  logic          frozen;
  logic [MW:0]   word_count;
  logic [15:0]   dropped_count;

  spy_write_controller #(.DATAWIDTH(DW), .MEMWIDTH(MW), .DROPWIDTH(16)) dut (
    .clock(clock), .reset(reset), .write_enable(write_enable), .write_data(write_data),
    .playback(playback), .ram_write_enable(ram_write_enable), .ram_write_data(ram_write_data),
    .freeze_request(freeze_request), .freeze_delay(freeze_delay), .freeze_clear(freeze_clear),
    .spy_write_enable(spy_write_enable), .spy_write_addr(spy_write_addr),
    .spy_write_data(spy_write_data), .frozen(frozen), .word_count(word_count),
    .dropped_count(dropped_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic we; logic [DW:0] wd; logic [1:0] pb; logic rwe; logic [DW:0] rwd;
    logic freq; logic [MW-1:0] fdel; logic fclr;
  } in_t;

  typedef struct {
    in_t in;
    logic en; int addr; logic [DW:0] data; logic frz; int wc; int drop;
  } row_t;

  int compared = 0;
  int mismatched = 0;

  // Behavioural model: spec-level mode plus integer address/counters.
  typedef enum int {M_REC, M_FREEZING, M_FROZEN, M_PB} mode_t;
  mode_t       m_mode;
  int          m_addr, m_count, m_drop, m_left, m_prev_pb;
  bit          m_en;
  logic [DW:0] m_data;

  task automatic chk(input string name, input logic [DW:0] act, input logic [DW:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_REC; m_addr = DEPTH - 1; m_count = 0; m_drop = 0; m_left = 0;
    m_prev_pb = 0; m_en = 1'b0; m_data = '0;
  endtask

  function automatic bit counts_toward_freeze(input logic [DW:0] d);
`ifdef SPY_META_FREEZE_EN
    return d[DW];
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_step(input in_t v);
    bit wr = 1'b0;
    logic [DW:0] src = v.wd;
    bit cnt;
    if (v.pb != 2'd0) begin
      if (v.pb == 2'd3 && m_prev_pb != 3) begin m_addr = DEPTH - 1; m_count = 0; end
      if (v.we) m_drop++;
      if (v.pb == 2'd3 && v.rwe) begin wr = 1'b1; src = v.rwd; end
      m_mode = M_PB;
    end else begin
      case (m_mode)
        M_PB: begin if (v.we) m_drop++; m_mode = M_FROZEN; end
        M_FROZEN: begin if (v.we) m_drop++; if (v.fclr) m_mode = M_REC; end
        M_REC: begin
          wr = v.we;
          if (!v.fclr && v.freq) begin
            if (v.fdel == 0) m_mode = M_FROZEN;
            else begin m_mode = M_FREEZING; m_left = v.fdel; end
          end
        end
        default: begin
          wr = v.we;
          cnt = v.we && counts_toward_freeze(v.wd);
          if (cnt) m_left--;
          if (v.fclr) m_mode = M_REC;
          else if (cnt && m_left == 0) m_mode = M_FROZEN;
        end
      endcase
    end
    if (m_drop > 65535) m_drop = 65535;
    m_en = wr;
    if (wr) begin
      m_addr = (m_addr + 1) % DEPTH;
      m_data = src;
      if (m_count < DEPTH) m_count++;
    end
    m_prev_pb = v.pb;
  endtask

  task automatic check_model();
    chk("en", {{DW{1'b0}}, spy_write_enable}, {{DW{1'b0}}, m_en});
    chk("addr", (DW+1)'(spy_write_addr), (DW+1)'(m_addr));
    chk("data", spy_write_data, m_data);
    chk("frozen", {{DW{1'b0}}, frozen}, {{DW{1'b0}}, (m_mode == M_FROZEN)});
    chk("word_count", (DW+1)'(word_count), (DW+1)'(m_count));
    chk("dropped", (DW+1)'(dropped_count), (DW+1)'(m_drop));
  endtask

  // Drive one cycle of inputs, advance model at the edge, compare after it.
  task automatic step(input in_t v);
    write_enable = v.we; write_data = v.wd; playback = v.pb;
    ram_write_enable = v.rwe; ram_write_data = v.rwd;
    freeze_request = v.freq; freeze_delay = v.fdel; freeze_clear = v.fclr;
    @(posedge clock);
    model_step(v);
    #1;
    check_model();
  endtask

  function automatic in_t mk_in(input logic we, input logic [DW:0] wd, input logic [1:0] pb,
                                input logic rwe, input logic [DW:0] rwd, input logic freq,
                                input logic [MW-1:0] fdel, input logic fclr);
    in_t v;
    v.we = we; v.wd = wd; v.pb = pb; v.rwe = rwe; v.rwd = rwd;
    v.freq = freq; v.fdel = fdel; v.fclr = fclr;
    return v;
  endfunction

  function automatic in_t wr_in(input logic [DW:0] d);
    return mk_in(1'b1, d, 2'd0, 1'b0, '0, 1'b0, '0, 1'b0);
  endfunction

  function automatic in_t idle_in();
    return mk_in(1'b0, '0, 2'd0, 1'b0, '0, 1'b0, '0, 1'b0);
  endfunction

  function automatic row_t mk_row(input in_t v, input logic en, input int addr,
                                 input logic [DW:0] data, input logic frz, input int wc, input int drop);
    row_t r;
    r.in = v; r.en = en; r.addr = addr; r.data = data; r.frz = frz; r.wc = wc; r.drop = drop;
    return r;
  endfunction

  task automatic apply_reset();
    reset = 1'b1;
    write_enable = 1'b0; write_data = '0; playback = NO_PLAYBACK; ram_write_enable = 1'b0;
    ram_write_data = '0; freeze_request = 1'b0; freeze_delay = '0; freeze_clear = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    model_reset();
    reset = 1'b0;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_en"}, {{DW{1'b0}}, spy_write_enable}, '0);
    chk({tag, "_addr"}, (DW+1)'(spy_write_addr), (DW+1)'(DEPTH - 1));
    chk({tag, "_data"}, spy_write_data, '0);
    chk({tag, "_frozen"}, {{DW{1'b0}}, frozen}, '0);
    chk({tag, "_wc"}, (DW+1)'(word_count), '0);
    chk({tag, "_drop"}, (DW+1)'(dropped_count), '0);
  endtask

  row_t rows[$];

  initial begin
    logic [DW:0] dd, de, r0;
    int stored, drop0, addr0;
    in_t v;

    dd = {1'b1, 64'hD};
    de = {1'b1, 64'hE};
    r0 = 65'h1_0000_0000_0000_5000;

    rows.push_back(mk_row(wr_in(65'hA), 1, 0, 65'hA, 0, 1, 0));
    rows.push_back(mk_row(wr_in(65'hB), 1, 1, 65'hB, 0, 2, 0));
    rows.push_back(mk_row(wr_in(65'hC), 1, 2, 65'hC, 0, 3, 0));
    rows.push_back(mk_row(idle_in(), 0, 2, 65'hC, 0, 3, 0));
    rows.push_back(mk_row(mk_in(0, '0, 2'd0, 0, '0, 1, 6'd2, 0), 0, 2, 65'hC, 0, 3, 0));
    rows.push_back(mk_row(wr_in(dd), 1, 3, dd, 0, 4, 0));
    rows.push_back(mk_row(wr_in(de), 1, 4, de, 1, 5, 0));
    rows.push_back(mk_row(wr_in(65'hF), 0, 4, de, 1, 5, 1));
    rows.push_back(mk_row(mk_in(1, 65'h6, 2'd0, 0, '0, 1, 6'd3, 1), 0, 4, de, 0, 5, 2));
    rows.push_back(mk_row(wr_in(65'h7), 1, 5, 65'h7, 0, 6, 2));
    rows.push_back(mk_row(mk_in(1, 65'h8, 2'd0, 0, '0, 1, 6'd5, 1), 1, 6, 65'h8, 0, 7, 2));
    rows.push_back(mk_row(mk_in(1, 65'h9, 2'd0, 0, '0, 1, 6'd0, 0), 1, 7, 65'h9, 1, 8, 2));
    rows.push_back(mk_row(wr_in(65'h1F), 0, 7, 65'h9, 1, 8, 3));
    rows.push_back(mk_row(mk_in(1, 65'h2F, PLAYBACK_WRITE, 0, '0, 0, '0, 0), 0, 63, 65'h9, 0, 0, 4));
    for (int i = 0; i < 5; i++)
      rows.push_back(mk_row(mk_in(0, '0, PLAYBACK_WRITE, 1, r0 + (DW+1)'(i), 0, '0, 0),
                            1, i, r0 + (DW+1)'(i), 0, i + 1, 4));
    rows.push_back(mk_row(wr_in(65'h3F), 0, 4, r0 + 65'd4, 1, 5, 5));
    rows.push_back(mk_row(wr_in(65'h4F), 0, 4, r0 + 65'd4, 1, 5, 6));
    rows.push_back(mk_row(mk_in(0, '0, PLAYBACK_ONCE, 0, '0, 0, '0, 0), 0, 4, r0 + 65'd4, 0, 5, 6));
    rows.push_back(mk_row(mk_in(0, '0, PLAYBACK_WRITE, 1, r0 + 65'd5, 0, '0, 0), 1, 0, r0 + 65'd5, 0, 1, 6));
    rows.push_back(mk_row(idle_in(), 0, 0, r0 + 65'd5, 1, 1, 6));
    rows.push_back(mk_row(mk_in(0, '0, 2'd0, 0, '0, 0, '0, 1), 0, 0, r0 + 65'd5, 0, 1, 6));
    rows.push_back(mk_row(wr_in(65'h5A), 1, 1, 65'h5A, 0, 2, 6));

    apply_reset();
    chk_reset_values("reset");

    foreach (rows[i]) begin
      step(rows[i].in);
      chk($sformatf("row%0d_en", i), {{DW{1'b0}}, spy_write_enable}, {{DW{1'b0}}, rows[i].en});
      chk($sformatf("row%0d_addr", i), (DW+1)'(spy_write_addr), (DW+1)'(rows[i].addr));
      chk($sformatf("row%0d_data", i), spy_write_data, rows[i].data);
      chk($sformatf("row%0d_frozen", i), {{DW{1'b0}}, frozen}, {{DW{1'b0}}, rows[i].frz});
      chk($sformatf("row%0d_wc", i), (DW+1)'(word_count), (DW+1)'(rows[i].wc));
      chk($sformatf("row%0d_drop", i), (DW+1)'(dropped_count), (DW+1)'(rows[i].drop));
    end

    // 70 consecutive writes: wrap and saturation.
    apply_reset();
    for (int i = 0; i < 70; i++) begin
      step(wr_in((DW+1)'(i + 100)));
      if (i == 63) chk("wrap_last", (DW+1)'(spy_write_addr), 65'd63);
      if (i == 64) chk("wrap_first", (DW+1)'(spy_write_addr), 65'd0);
    end
    chk("wrap_final_addr", (DW+1)'(spy_write_addr), 65'd5);
    chk("wrap_sat_count", (DW+1)'(word_count), 65'd64);

    // Freeze with delay 4 then 10 writes (meta set so both builds agree).
    step(mk_in(0, '0, 2'd0, 0, '0, 1, 6'd4, 0));
    stored = 0;
    drop0 = dropped_count;
    for (int i = 0; i < 10; i++) begin
      step(wr_in({1'b1, 64'(i + 200)}));
      if (spy_write_enable) stored++;
      chk($sformatf("frz_frozen_%0d", i), {{DW{1'b0}}, frozen}, {{DW{1'b0}}, (i >= 3)});
    end
    chk("frz_stored", (DW+1)'(stored), 65'd4);
    chk("frz_dropped", (DW+1)'(dropped_count - 16'(drop0)), 65'd6);
    chk("frz_addr", (DW+1)'(spy_write_addr), 65'd9);
    step(mk_in(0, '0, 2'd0, 0, '0, 0, '0, 1));
    addr0 = spy_write_addr;
    step(wr_in(65'h77));
    chk("unfreeze_addr", (DW+1)'(spy_write_addr), (DW+1)'(addr0 + 1));

    // Asynchronous reset while FREEZING with two words remaining.
    step(mk_in(0, '0, 2'd0, 0, '0, 1, 6'd4, 0));
    step(wr_in(65'h1));
    step(wr_in(65'h2));
    reset = 1'b1;
    #1;
    chk_reset_values("async_reset");
    model_reset();
    #1;
    reset = 1'b0;
    step(wr_in(65'h3));
    chk("post_reset_accept", (DW+1)'(spy_write_addr), 65'd0);

`ifdef SPY_META_FREEZE_EN
    // Meta-gated freeze: meta on every third word, delay 2.
    apply_reset();
    step(mk_in(0, '0, 2'd0, 0, '0, 1, 6'd2, 0));
    stored = 0;
    for (int i = 0; i < 9; i++) begin
      step(wr_in({(i % 3 == 2), 64'(i + 300)}));
      if (spy_write_enable) stored++;
    end
    chk("meta_stored", (DW+1)'(stored), 65'd6);
    chk("meta_last_bit", {{DW{1'b0}}, spy_write_data[DW]}, 65'd1);
    chk("meta_frozen", {{DW{1'b0}}, frozen}, 65'd1);
`endif

    // Randomized traffic against the model.
    apply_reset();
    for (int n = 0; n < 1500; n++) begin
      v.we   = $urandom_range(0, 3) != 0;
      v.wd   = {($urandom_range(0, 2) == 0), $urandom(), $urandom()};
      v.pb   = ($urandom_range(0, 15) < 12) ? 2'd0 : 2'($urandom_range(0, 3));
      v.rwe  = $urandom_range(0, 1) != 0;
      v.rwd  = {1'($urandom_range(0, 1)), $urandom(), $urandom()};
      v.freq = $urandom_range(0, 19) == 0;
      v.fdel = MW'($urandom_range(0, 7));
      v.fclr = $urandom_range(0, 29) == 0;
      step(v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
